// File: rtl/crc_pkg.sv
// Shared constants and FSM state encoding for the CRC receive-path arbiter.
package crc_pkg;

    localparam int unsigned BW_DEF     = 4;
    localparam int unsigned CRC_BW_DEF = 3;
    localparam logic [3:0]  CRC3_DIVISOR = 4'b1011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/crc_syndrome.sv
// Combinational GF(2) long division: remainder of a codeword modulo DIVISOR.
module crc_syndrome #(
    parameter int unsigned     BW      = 4,
    parameter int unsigned     CRC_BW  = 3,
    parameter logic [CRC_BW:0] DIVISOR = 4'b1011
) (
    input  logic [BW+CRC_BW-1:0] word,
    output logic [CRC_BW-1:0]    syndrome
);

    localparam int unsigned W = BW + CRC_BW;
    // Divisor aligned under the codeword MSB; the remainder shifts up into place.
    localparam logic [W-1:0] DIV_ALIGNED = W'({DIVISOR, {(BW-1){1'b0}}});

    logic [W-1:0] rem;

    always_comb begin
        rem = word;
        for (int unsigned k = 0; k < BW; k++) begin
            if (rem[W-1]) begin
                rem = rem ^ DIV_ALIGNED;
            end
            rem = rem << 1;
        end
        syndrome = rem[W-1 -: CRC_BW];
    end

endmodule

// File: rtl/crc_rx_arbiter.sv
// Round-robin arbiter sharing one CRC syndrome checker between N_REQ sources,
// with per-source consecutive-error fault tracking and a saturating error count.
module crc_rx_arbiter
    import crc_pkg::*;
#(
    parameter int unsigned     BW        = BW_DEF,
    parameter int unsigned     CRC_BW    = CRC_BW_DEF,
    parameter logic [CRC_BW:0] DIVISOR   = CRC3_DIVISOR,
    parameter int unsigned     N_REQ     = 2,
    parameter int unsigned     MAX_RETRY = 3,
    parameter int unsigned     CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*(BW+CRC_BW)-1:0] req_word,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         out_valid,
    output logic [BW-1:0]                out_data,
    output logic [$clog2(N_REQ)-1:0]     out_src,
    output logic                         out_err,
    output logic [N_REQ-1:0]             nack,
    output logic [N_REQ-1:0]             fault,
    output logic [CNT_W-1:0]             err_cnt
);

    localparam int unsigned W       = BW + CRC_BW;
    localparam int unsigned SRC_W   = $clog2(N_REQ);
    localparam int unsigned RETRY_W = 4;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   ptr, src_q, grant_idx, cand;
    logic               grant_found, take, err_q;
    logic [W-1:0]       word_q;
    logic [W-1:0]       words [N_REQ];
    logic [N_REQ-1:0]   eligible;
    logic [CRC_BW-1:0]  syndrome;
    logic [RETRY_W-1:0] retry [N_REQ];
    logic [RETRY_W-1:0] retry_inc;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign words[g] = req_word[g*W +: W];
    end

    assign eligible  = req_valid & ~fault;
    assign retry_inc = retry[src_q] + RETRY_W'(1);

    // First eligible source at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = SRC_W'((32'(ptr) + k) % N_REQ);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        take      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    take                 = 1'b1;
                    state_d              = CHECK;
                end
            end
            CHECK:   state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    crc_syndrome #(
        .BW      (BW),
        .CRC_BW  (CRC_BW),
        .DIVISOR (DIVISOR)
    ) u_syndrome (
        .word     (word_q),
        .syndrome (syndrome)
    );

    // Result, fault and counter registers all update on the edge that leaves REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            src_q     <= '0;
            word_q    <= '0;
            err_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_err   <= 1'b0;
            nack      <= '0;
            fault     <= '0;
            err_cnt   <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                retry[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            nack      <= '0;
            if (take) begin
                word_q <= words[grant_idx];
                src_q  <= grant_idx;
                ptr    <= SRC_W'((32'(grant_idx) + 32'd1) % N_REQ);
            end
            if (state_q == CHECK) begin
                err_q <= |syndrome;
            end
            if (state_q == REPORT) begin
                out_valid <= 1'b1;
                out_src   <= src_q;
                out_err   <= err_q;
                out_data  <= err_q ? '0 : word_q[W-1 -: BW];
                if (err_q) begin
                    nack[src_q] <= 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                    if (retry[src_q] != '1) begin
                        retry[src_q] <= retry_inc;
                    end
                    if (retry_inc >= RETRY_W'(MAX_RETRY)) begin
                        fault[src_q] <= 1'b1;
                    end
                end else begin
                    retry[src_q] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_rx_arbiter.sv
// Directed self-checking bench for crc_rx_arbiter (N_REQ=2, CRC-3 over 4-bit data).
module tb_crc_rx_arbiter;

    localparam logic [6:0] GOOD = 7'b1101001;
    localparam logic [6:0] BAD  = 7'b1100001;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [13:0] req_word;
    logic [1:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [0:0]  out_src;
    logic        out_err;
    logic [1:0]  nack;
    logic [1:0]  fault;
    logic [7:0]  err_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    crc_rx_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_word  (req_word),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_err   (out_err),
        .nack      (nack),
        .fault     (fault),
        .err_cnt   (err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid is seen; gives up after 10.
    task automatic wait_out(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 10) begin
            tick();
            cycles++;
            if (out_valid) seen = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int unsigned rsum;
        rst       = 1'b1;
        req_valid = 2'b11;
        req_word  = {GOOD, GOOD};
        tick();
        tick();
        total++; if (req_ready !== 2'b00) $display("FAIL reset_ready got %b exp 00", req_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else passed++;
        rsum = {out_data, out_src, out_err, nack, fault, err_cnt};
        total++; if (rsum !== 0) $display("FAIL reset_outputs got %0h exp 0", rsum); else passed++;
        rst       = 1'b0;
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_clean();
        int cyc;
        req_word  = {GOOD, GOOD};
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) $display("FAIL clean_ready got %b exp 01", req_ready); else passed++;
        wait_out(cyc);
        req_valid = 2'b00;
        total++; if (cyc !== 3) $display("FAIL clean_latency got %0d exp 3", cyc); else passed++;
        total++; if (out_data !== 4'b1101) $display("FAIL clean_data got %b exp 1101", out_data); else passed++;
        total++; if (out_src !== 1'b0) $display("FAIL clean_src got %0d exp 0", out_src); else passed++;
        total++; if (out_err !== 1'b0) $display("FAIL clean_err got %b exp 0", out_err); else passed++;
        total++; if (nack !== 2'b00) $display("FAIL clean_nack got %b exp 00", nack); else passed++;
        total++; if (err_cnt !== 8'd0) $display("FAIL clean_errcnt got %0d exp 0", err_cnt); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL clean_strobe_len got %b exp 0", out_valid); else passed++;
        total++; if (out_data !== 4'b1101) $display("FAIL clean_data_hold got %b exp 1101", out_data); else passed++;
    endtask

    task automatic test_corrupt();
        int cyc;
        req_word  = {BAD, GOOD};
        req_valid = 2'b10;
        wait_out(cyc);
        req_valid = 2'b00;
        total++; if (cyc !== 3) $display("FAIL corrupt_latency got %0d exp 3", cyc); else passed++;
        total++; if (out_err !== 1'b1) $display("FAIL corrupt_err got %b exp 1", out_err); else passed++;
        total++; if (out_data !== 4'b0000) $display("FAIL corrupt_data got %b exp 0000", out_data); else passed++;
        total++; if (out_src !== 1'b1) $display("FAIL corrupt_src got %0d exp 1", out_src); else passed++;
        total++; if (nack !== 2'b10) $display("FAIL corrupt_nack got %b exp 10", nack); else passed++;
        total++; if (err_cnt !== 8'd1) $display("FAIL corrupt_errcnt got %0d exp 1", err_cnt); else passed++;
        tick();
        total++; if (nack !== 2'b00) $display("FAIL corrupt_nack_len got %b exp 00", nack); else passed++;
    endtask

    task automatic test_round_robin();
        int cyc;
        req_word  = {GOOD, GOOD};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_out(cyc);
            if (i == 3) req_valid = 2'b00;
            total++; if (cyc !== 3) $display("FAIL rr_spacing[%0d] got %0d exp 3", i, cyc); else passed++;
            total++; if (out_src !== 1'(i % 2)) $display("FAIL rr_src[%0d] got %0d exp %0d", i, out_src, i % 2); else passed++;
            total++; if (out_err !== 1'b0) $display("FAIL rr_err[%0d] got %b exp 0", i, out_err); else passed++;
        end
        tick();
    endtask

    task automatic test_fault();
        int cyc;
        int results;
        bit saw1;
        pulse_reset();
        req_word  = {BAD, GOOD};
        req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            wait_out(cyc);
            total++; if (cyc !== 3) $display("FAIL fault_spacing[%0d] got %0d exp 3", i, cyc); else passed++;
            if (i == 1) begin
                total++; if (fault !== 2'b00) $display("FAIL fault_early got %b exp 00", fault); else passed++;
            end
        end
        total++; if (fault !== 2'b10) $display("FAIL fault_set got %b exp 10", fault); else passed++;
        total++; if (err_cnt !== 8'd3) $display("FAIL fault_errcnt got %0d exp 3", err_cnt); else passed++;
        req_word  = {GOOD, GOOD};
        req_valid = 2'b11;
        results   = 0;
        saw1      = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (req_ready[1]) saw1 = 1'b1;
            if (out_valid) begin
                results++;
                total++; if (out_src !== 1'b0) $display("FAIL fault_only_src0 got %0d exp 0", out_src); else passed++;
            end
        end
        req_valid = 2'b00;
        total++; if (saw1 !== 1'b0) $display("FAIL fault_ready1 got %b exp 0", saw1); else passed++;
        total++; if (results !== 3) $display("FAIL fault_results got %0d exp 3", results); else passed++;
        total++; if (fault !== 2'b10) $display("FAIL fault_sticky got %b exp 10", fault); else passed++;
        tick();
    endtask

    task automatic test_reset_midflight();
        int cyc;
        bit saw_out;
        int unsigned rsum;
        req_word  = {GOOD, GOOD};
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        rsum = {out_data, out_src, out_err, nack, fault, err_cnt};
        total++; if (rsum !== 0) $display("FAIL mid_outputs got %0h exp 0", rsum); else passed++;
        saw_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid || nack != 2'b00) saw_out = 1'b1;
            tick();
        end
        total++; if (saw_out !== 1'b0) $display("FAIL mid_no_result got %b exp 0", saw_out); else passed++;
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) $display("FAIL mid_ptr_zero got %b exp 01", req_ready); else passed++;
        req_valid = 2'b10;
        #1;
        total++; if (req_ready !== 2'b10) $display("FAIL mid_src1_ready got %b exp 10", req_ready); else passed++;
        wait_out(cyc);
        req_valid = 2'b00;
        total++; if (cyc !== 3) $display("FAIL mid_latency got %0d exp 3", cyc); else passed++;
        total++; if (out_src !== 1'b1) $display("FAIL mid_src got %0d exp 1", out_src); else passed++;
        total++; if (out_data !== 4'b1101) $display("FAIL mid_data got %b exp 1101", out_data); else passed++;
        tick();
    endtask

    task automatic test_retry_clear();
        logic [6:0] seq [5];
        logic       exp_err [5];
        int cyc;
        seq     = '{BAD, BAD, GOOD, BAD, BAD};
        exp_err = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            req_word = {GOOD, seq[i]};
            wait_out(cyc);
            if (i == 4) req_valid = 2'b00;
            total++; if (out_err !== exp_err[i]) $display("FAIL retry_err[%0d] got %b exp %b", i, out_err, exp_err[i]); else passed++;
            total++; if (fault !== 2'b00) $display("FAIL retry_fault[%0d] got %b exp 00", i, fault); else passed++;
        end
        total++; if (err_cnt !== 8'd4) $display("FAIL retry_errcnt got %0d exp 4", err_cnt); else passed++;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_word  = '0;
        test_reset();
        test_clean();
        test_corrupt();
        test_round_robin();
        test_fault();
        test_reset_midflight();
        test_retry_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/crc_rx_arbiter.md
Name: crc_rx_arbiter

Overview:
- Shares one CRC-3 syndrome checker between N_REQ codeword sources.
- Sources present a (data, CRC) codeword with a valid/ready handshake; grants are round-robin.
- Each granted word is checked and reported with its source ID and an error flag. A NACK goes back to the source on error.
- Per-source consecutive-error tracking sets a sticky fault and removes a failing source from arbitration.
- Sits between the link-side senders and the downstream data consumer in the CRC_N receive path.

Parameters:
- BW, 4, data bits per codeword.
- CRC_BW, 3, CRC bits per codeword.
- DIVISOR, 4'b1011, generator polynomial, CRC_BW+1 bits.
- N_REQ, 2, number of requesters, 2..8.
- MAX_RETRY, 3, consecutive errors from one source that set its fault, 1..15.
- CNT_W, 8, width of the total error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- req_valid  in  N_REQ  per-source codeword valid.
- req_word  in  N_REQ*(BW+CRC_BW)  packed codewords; source i occupies slice i. In each slice, data is the MSBs and CRC the LSBs.
- req_ready  out  N_REQ  one-hot grant; handshake when req_valid[i]&req_ready[i].
- out_valid  out  1  single-cycle result strobe.
- out_data  out  BW  data field of the checked word; forced to 0 when out_err=1.
- out_src  out  clog2(N_REQ)  source index of the result.
- out_err  out  1  syndrome nonzero.
- nack  out  N_REQ  one-cycle pulse to the source whose word failed.
- fault  out  N_REQ  sticky per-source fault.
- err_cnt  out  CNT_W  total CRC errors, saturating.

Behaviour:
- Reset: while rst=1 at a clock edge, all of the following are cleared:
  - out_valid, out_data, out_src, out_err, nack, fault, err_cnt.
  - Retry counters.
  - Round-robin pointer, reset to 0.
  - FSM, reset to IDLE.
  - req_ready is 0 while rst=1.
- Reset mid-operation: a word in CHECK or REPORT is discarded with no out_valid and no nack.
- FSM states: IDLE, CHECK, REPORT.
- IDLE:
  - eligible = req_valid & ~fault.
  - The grant is the first eligible index at or after the round-robin pointer, wrapping N_REQ-1 -> 0.
  - req_ready is combinational, one-hot on that index, and is asserted only in IDLE.
  - On handshake: latch the word and source index, set the pointer to granted index+1 (mod N_REQ), go to CHECK.
  - No eligible source: stay in IDLE, req_ready=0.
- CHECK:
  - The syndrome is the remainder of word mod DIVISOR over GF(2), computed combinationally from the latched word.
  - Register err = |syndrome, then go to REPORT.
- REPORT:
  - out_valid=1 for exactly one cycle, with out_src, out_err and out_data.
  - If err: nack[src]=1 for the same cycle; err_cnt increments, holding at all-ones once saturated; retry[src] increments.
  - If retry[src] reaches MAX_RETRY, fault[src] is set in the same cycle.
  - If not err: retry[src] clears.
  - Always go to IDLE.
- Latency: handshake at edge t gives out_valid high in the cycle after edge t+2. Throughput is one word per 3 cycles.
- Outputs out_data, out_src and out_err hold their values between strobes. nack is 0 outside REPORT.
- A faulted source is never granted. Its req_valid is ignored and receives no ready. Only rst clears fault.
- All sources faulted: stay in IDLE permanently, req_ready=0.
- A source that deasserts valid before it is granted loses nothing; no state is kept for it.

Decomposition:
- Shared package crc_pkg holds:
  - constants CRC3_DIVISOR=4'b1011, default BW/CRC_BW;
  - the FSM state enum (IDLE/CHECK/REPORT).
- Sub-module crc_syndrome (combinational, parameterised by BW, CRC_BW and DIVISOR) performs the polynomial long division. It is instantiated once in the CHECK path.
- Arbiter, FSM and counters stay in the top module.

Test Plan:
- Clean word: src0 sends 7'b1101001 (data 1101, CRC 001) -> req_ready[0] at handshake; 3 cycles later out_valid=1, out_data=4'b1101, out_src=0, out_err=0, nack=0, err_cnt=0.
- Corrupted word: src1 sends 7'b1100001 -> out_err=1, out_data=0, out_src=1, nack[1] pulses for 1 cycle, err_cnt=1.
- Round-robin: both sources hold valid with clean words -> grant order 0,1,0,1 over 4 results spaced 3 cycles apart; no source granted twice in a row.
- Fault: src1 sends 1100001 three times, then 1101001 -> the third result sets fault[1]=1 and err_cnt=3. After that only src0 is granted; src1 never sees req_ready again, even with valid held.
- Retry clear: src0 sends bad, bad, good, bad, bad -> fault[0] stays 0 throughout (the counter cleared on the good word); err_cnt=4.
- Reset mid-flight: assert rst for 1 cycle during CHECK -> no out_valid, all outputs 0, pointer 0. The next request from src1 alone is granted normally.
